// File: rtl/pulse_pkg.sv
// Shared state encoding, default sizing and timer-width helper for the
// up/down pulse generator.
package pulse_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_PULSE = 2'd1;
  localparam state_t S_GAP   = 2'd2;

  localparam int PULSE_CYC_DEF = 10;
  localparam int GAP_CYC_DEF   = 1;
  localparam int CNT_W_DEF     = 8;

  // Timer holds duration-1 down to 0, so it needs bits for max_cyc-1 only.
  function automatic int timer_w(input int max_cyc);
    return (max_cyc > 1) ? $clog2(max_cyc) : 1;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expiry flag marks the last cycle of a PULSE or GAP.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/updown_pulse_gen.sv
// Emits REQ_COUNT fixed-width pulses on UP_OUT/DOWN_OUT, each followed by a gap.
//   state | meaning
//   IDLE  | ready for a request, both outputs low
//   PULSE | one output high for PULSE_CYC cycles
//   GAP   | both outputs low for GAP_CYC cycles
module updown_pulse_gen
  import pulse_pkg::*;
#(
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_DIR,
  input  logic             REQ_ALT,
  input  logic [CNT_W-1:0] REQ_COUNT,
  input  logic             ABORT,
  output logic             UP_OUT,
  output logic             DOWN_OUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TW      = timer_w(MAX_CYC);
  localparam logic [TW-1:0] P_LOAD = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] G_LOAD = TW'(GAP_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             alt_q, alt_d;
  logic             abort_q, abort_d;
  logic             ready_q, done_q, done_d;
  logic             up_q, dn_q;
  logic             t_load, t_exp;
  logic [TW-1:0]    t_val;
  logic             accept;

  assign accept = REQ_VALID && ready_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    alt_d   = alt_q;
    abort_d = abort_q;
    done_d  = 1'b0;
    t_load  = 1'b0;
    t_val   = P_LOAD;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dir_d   = REQ_DIR;
          alt_d   = REQ_ALT;
          rem_d   = REQ_COUNT;
          abort_d = 1'b0;
          if (REQ_COUNT != '0) begin
            state_d = S_PULSE;
            t_load  = 1'b1;
            t_val   = P_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_PULSE: begin
        // Abort wins over a same-cycle timer expiry.
        if (ABORT) begin
          state_d = S_GAP;
          rem_d   = '0;
          abort_d = 1'b1;
          t_load  = 1'b1;
          t_val   = G_LOAD;
        end else if (t_exp) begin
          state_d = S_GAP;
          if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
          if (alt_q) dir_d = ~dir_q;
          t_load  = 1'b1;
          t_val   = G_LOAD;
        end
      end
      S_GAP: begin
        if (ABORT) begin
          rem_d   = '0;
          abort_d = 1'b1;
        end
        if (t_exp) begin
          if (ABORT || abort_q || (rem_q == '0)) begin
            state_d = S_IDLE;
            done_d  = !(ABORT || abort_q);
          end else begin
            state_d = S_PULSE;
            t_load  = 1'b1;
            t_val   = P_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      alt_q   <= 1'b0;
      abort_q <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      alt_q   <= alt_d;
      abort_q <= abort_d;
      ready_q <= (state_d == S_IDLE);
      done_q  <= done_d;
      up_q    <= (state_d == S_PULSE) && dir_d;
      dn_q    <= (state_d == S_PULSE) && !dir_d;
    end
  end

  cycle_timer #(.W(TW)) u_timer (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (t_load),
    .load_val_i (t_val),
    .en_i       (state_q != S_IDLE),
    .expired_o  (t_exp)
  );

  assign REQ_READY = ready_q;
  assign UP_OUT    = up_q;
  assign DOWN_OUT  = dn_q;
  assign DONE      = done_q;
  assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_updown_pulse_gen.sv
// Scoreboard bench: tests queue expected pulse/gap/done events, a monitor
// rebuilds events from the output lines and compares them in order.
module tb_updown_pulse_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic       REQ_DIR = 1'b0;
  logic       REQ_ALT = 1'b0;
  logic [7:0] REQ_COUNT = 8'd0;
  logic       ABORT = 1'b0;
  logic       REQ_READY, UP_OUT, DOWN_OUT, BUSY, DONE;

  always #5 CLK = ~CLK;

  updown_pulse_gen #(.PULSE_CYC(10), .GAP_CYC(1), .CNT_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_DIR   (REQ_DIR),
    .REQ_ALT   (REQ_ALT),
    .REQ_COUNT (REQ_COUNT),
    .ABORT     (ABORT),
    .UP_OUT    (UP_OUT),
    .DOWN_OUT  (DOWN_OUT),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  // kind: 0 = pulse (dir, len), 1 = gap (len), 2 = done strobe
  typedef struct {
    int kind;
    bit dir;
    int len;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  plen = 0;
  int  glen = 0;
  bit  pdir = 1'b0;

  task automatic push_ev(input int k, input bit d, input int l);
    ev_t e;
    e.kind = k; e.dir = d; e.len = l;
    exp_q.push_back(e);
  endtask

  task automatic emit(input int k, input bit d, input int l);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind=%0d dir=%0d len=%0d, required no event", k, d, l);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == 0 && e.dir != d) || (k != 2 && e.len != l)) begin
        errors++;
        $display("FAIL event: got kind=%0d dir=%0d len=%0d, required kind=%0d dir=%0d len=%0d",
                 k, d, l, e.kind, e.dir, e.len);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: turns output lines into events on the falling edge
  always @(negedge CLK) begin
    if (RST) begin
      plen = 0;
      glen = 0;
    end else begin
      checks++;
      if (UP_OUT && DOWN_OUT) begin
        errors++;
        $display("FAIL both_high: got UP=1 DOWN=1, required at most one high");
      end
      if (UP_OUT || DOWN_OUT) begin
        if (glen > 0) begin emit(1, 1'b0, glen); glen = 0; end
        if (plen == 0) pdir = UP_OUT;
        plen++;
      end else begin
        if (plen > 0) begin emit(0, pdir, plen); plen = 0; end
        if (BUSY) glen++;
        else if (glen > 0) begin emit(1, 1'b0, glen); glen = 0; end
      end
      if (DONE) emit(2, 1'b0, 0);
    end
  end

  task automatic issue(input bit d, input bit a, input logic [7:0] c);
    int n = 0;
    @(negedge CLK);
    while (!REQ_READY && n < 1000) begin @(negedge CLK); n++; end
    chk("ready_wait_timeout", (n >= 1000), 0);
    REQ_VALID = 1'b1; REQ_DIR = d; REQ_ALT = a; REQ_COUNT = c;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (BUSY && n < 5000) begin @(negedge CLK); n++; end
    chk("idle_wait_timeout", (n >= 5000), 0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000");
    $fatal(1);
  end

  initial begin
    int b;
    int n;
    // Reset values
    #12;
    chk("rst_up", UP_OUT, 0);
    chk("rst_down", DOWN_OUT, 0);
    chk("rst_done", DONE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ready", REQ_READY, 0);
    @(posedge CLK); #1 RST = 1'b0;
    chk("ready_before_edge", REQ_READY, 0);
    @(posedge CLK); #1;
    chk("ready_after_release", REQ_READY, 1);

    // DIR=1 ALT=1 COUNT=4
    for (int i = 0; i < 4; i++) begin
      push_ev(0, (i % 2 == 0), 10);
      push_ev(1, 1'b0, 1);
    end
    push_ev(2, 1'b0, 0);
    issue(1'b1, 1'b1, 8'd4);
    b = 0;
    @(negedge CLK);
    while (BUSY && b < 200) begin b++; @(negedge CLK); end
    chk("busy_cycles", b, 44);
    chk("done_at_idle", DONE, 1);
    wait_idle();

    // DIR=0 ALT=0 COUNT=2
    push_ev(0, 1'b0, 10); push_ev(1, 1'b0, 1);
    push_ev(0, 1'b0, 10); push_ev(1, 1'b0, 1);
    push_ev(2, 1'b0, 0);
    issue(1'b0, 1'b0, 8'd2);
    wait_idle();

    // COUNT=0
    push_ev(2, 1'b0, 0);
    issue(1'b1, 1'b1, 8'd0);
    @(negedge CLK);
    chk("cnt0_done", DONE, 1);
    chk("cnt0_ready", REQ_READY, 1);
    chk("cnt0_busy", BUSY, 0);
    wait_idle();

    // ABORT on 5th cycle of 2nd pulse
    push_ev(0, 1'b1, 10); push_ev(1, 1'b0, 1);
    push_ev(0, 1'b0, 5);  push_ev(1, 1'b0, 1);
    issue(1'b1, 1'b1, 8'd4);
    repeat (15) @(posedge CLK);
    @(negedge CLK) ABORT = 1'b1;
    @(posedge CLK); #1 ABORT = 1'b0;
    wait_idle();
    chk("abort_ready", REQ_READY, 1);
    repeat (5) @(negedge CLK);

    // VALID held across completion; fields changed after accept
    push_ev(0, 1'b1, 10); push_ev(1, 1'b0, 1); push_ev(2, 1'b0, 0);
    push_ev(0, 1'b0, 10); push_ev(1, 1'b0, 1);
    push_ev(0, 1'b0, 10); push_ev(1, 1'b0, 1); push_ev(2, 1'b0, 0);
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_DIR = 1'b1; REQ_ALT = 1'b0; REQ_COUNT = 8'd1;
    @(posedge CLK); #1;
    REQ_DIR = 1'b0; REQ_COUNT = 8'd2;
    n = 0;
    @(negedge CLK);
    while (!REQ_READY && n < 200) begin @(negedge CLK); n++; end
    chk("held_valid_wait", n, 11);
    chk("held_valid_done", DONE, 1);
    @(posedge CLK); #1 REQ_VALID = 1'b0;
    wait_idle();

    // Maximum count, alternating
    for (int i = 0; i < 255; i++) begin
      push_ev(0, (i % 2 == 0), 10);
      push_ev(1, 1'b0, 1);
    end
    push_ev(2, 1'b0, 0);
    issue(1'b1, 1'b1, 8'd255);
    wait_idle();

    // Reset mid-pulse: no events expected
    issue(1'b1, 1'b0, 8'd3);
    repeat (3) @(posedge CLK);
    #2;
    chk("pre_rst_up", UP_OUT, 1);
    RST = 1'b1;
    #1;
    chk("async_up", UP_OUT, 0);
    chk("async_down", DOWN_OUT, 0);
    chk("async_busy", BUSY, 0);
    chk("async_ready", REQ_READY, 0);
    @(negedge CLK);
    chk("rst_hold_done", DONE, 0);
    @(posedge CLK); #1 RST = 1'b0;
    @(posedge CLK); #1;
    chk("ready_after_midrst", REQ_READY, 1);
    repeat (20) @(negedge CLK);
    chk("post_rst_busy", BUSY, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_pulse_gen.md
UPDOWN_PULSE_GEN -- requirements
Module: updown_pulse_gen

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 10: cycles each UP_OUT/DOWN_OUT pulse is high (legal range >=1).
REQ-002 SHALL have parameter GAP_CYC, default 1: cycles both outputs are low after every pulse (legal range >=1).
REQ-003 SHALL have parameter CNT_W, default 8: width of the pulse-count request.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port REQ_VALID, input, 1 bit: a request is presented.
REQ-008 SHALL have port REQ_READY, output, 1 bit: the block can accept a request.
REQ-009 SHALL have port REQ_DIR, input, 1 bit: first pulse direction (1 = up, 0 = down).
REQ-010 SHALL have port REQ_ALT, input, 1 bit: 1 = alternate direction after every pulse; 0 = all pulses in REQ_DIR.
REQ-011 SHALL have port REQ_COUNT, input, CNT_W bits: number of pulses to emit.
REQ-012 SHALL have port ABORT, input, 1 bit: synchronous early termination.
REQ-013 SHALL have ports UP_OUT and DOWN_OUT, output, 1 bit each: registered pulse lines to the downstream channel combiner's *_UP/*_DOWN inputs.
REQ-014 SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port DONE, output, 1 bit: one-cycle strobe on normal completion.

Function
REQ-016 SHALL implement states IDLE, PULSE and GAP.
REQ-017 SHALL drive REQ_READY high only in IDLE; a request is accepted on a cycle where REQ_VALID and REQ_READY are both high.
REQ-018 SHALL latch REQ_DIR, REQ_ALT and REQ_COUNT at accept and ignore later changes to them.
REQ-019 SHALL, on accept with REQ_COUNT > 0, enter PULSE so the selected output is high starting the cycle after accept.
REQ-020 SHALL hold the active output high for exactly PULSE_CYC cycles, then enter GAP with both outputs low for exactly GAP_CYC cycles.
REQ-021 SHALL decrement the remaining count at the end of each PULSE.
REQ-022 SHALL, at the end of GAP, return to PULSE if the remaining count is nonzero; otherwise go to IDLE with DONE high for that one cycle.
REQ-023 SHALL, when the latched REQ_ALT = 1, invert the direction at every PULSE-to-GAP transition.
REQ-024 SHALL, on accept with REQ_COUNT = 0, emit no pulse, stay in IDLE and assert DONE the next cycle.
REQ-025 SHALL never drive UP_OUT and DOWN_OUT high in the same cycle.
REQ-026 SHALL, when ABORT is high in PULSE, drive both outputs low the next cycle, clear the remaining count and serve a full GAP_CYC gap, then go to IDLE without DONE.
REQ-027 SHALL, when ABORT is high in GAP, clear the remaining count and complete the current gap, then go to IDLE without DONE.
REQ-028 SHALL ignore ABORT in IDLE; ABORT takes priority over a same-cycle count or timer expiry.
REQ-029 SHALL support REQ_COUNT = 2^CNT_W-1 with no wrap-around of the remaining count.

Reset
REQ-030 SHALL, while RST is high, force IDLE, UP_OUT=0, DOWN_OUT=0, DONE=0, BUSY=0, REQ_READY=0, with counters and timer cleared.
REQ-031 SHALL, on reset mid-pulse, drop the active output asynchronously, with no DONE after release.
REQ-032 SHALL raise REQ_READY on the first clock edge after RST deasserts.

Structure
REQ-033 SHALL place the state encoding and default PULSE_CYC, GAP_CYC and CNT_W constants in shared package pulse_pkg.
REQ-034 SHALL implement the PULSE/GAP duration counter as sub-module cycle_timer (load value, enable, expiry flag), sized to max(PULSE_CYC, GAP_CYC).

Verification
REQ-035 SHALL verify: with defaults, DIR=1, ALT=1, COUNT=4 -> UP 10 cycles, gap 1, DOWN 10, gap 1, UP 10, gap 1, DOWN 10, gap 1; then DONE for 1 cycle; BUSY high for 44 cycles.
REQ-036 SHALL verify: DIR=0, ALT=0, COUNT=2 -> two DOWN pulses of 10 cycles with a 1-cycle gap; UP_OUT never high.
REQ-037 SHALL verify: COUNT=0 -> no pulse; DONE the cycle after accept; REQ_READY back high immediately.
REQ-038 SHALL verify: ABORT on the 5th cycle of the 2nd pulse of COUNT=4 -> output low next cycle, 1 gap cycle, then IDLE, no DONE.
REQ-039 SHALL verify: RST asserted mid-pulse -> outputs low asynchronously; after release, REQ_READY=1 and no DONE.
REQ-040 SHALL verify: REQ_VALID held high across completion -> new request accepted only in IDLE; UP_OUT and DOWN_OUT are never both high in any test.
